// File: rtl/alu_seq_if.sv
// Execute-handshake bundle between the control unit (master) and the ALU (slave).
// Carries the bgn/rdy handshake, the latched opcode/operands and the results.
interface alu_seq_if #(
   parameter int WIDTH = 16
) ();
   logic             bgn;
   logic [5:0]       opcode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] acc1;
   logic [WIDTH-1:0] acc2;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             rdy;

   modport master (
      output bgn, opcode, A, B,
      input  acc1, acc2, zero, negative, carry, overflow, rdy
   );

   modport slave (
      input  bgn, opcode, A, B,
      output acc1, acc2, zero, negative, carry, overflow, rdy
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU answering the bgn/rdy execute handshake: single-cycle logic/arith ops,
// shift-add multiply and restoring divide, results and flags held until the next completion.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_LSR = 5'b00011;
   localparam logic [4:0] OP_LSL = 5'b00100;
   localparam logic [4:0] OP_RSR = 5'b00101;
   localparam logic [4:0] OP_RSL = 5'b00110;
   localparam logic [4:0] OP_MOV = 5'b00111;
   localparam logic [4:0] OP_MUL = 5'b01000;
   localparam logic [4:0] OP_DIV = 5'b01001;
   localparam logic [4:0] OP_MOD = 5'b01010;
   localparam logic [4:0] OP_AND = 5'b01011;
   localparam logic [4:0] OP_OR  = 5'b01100;
   localparam logic [4:0] OP_XOR = 5'b01101;
   localparam logic [4:0] OP_NOT = 5'b01110;
   localparam logic [4:0] OP_CMP = 5'b01111;
   localparam logic [4:0] OP_TST = 5'b10000;
   localparam logic [4:0] OP_INC = 5'b10001;
   localparam logic [4:0] OP_DEC = 5'b10010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_e;

   function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] r);
      return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] r);
      return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] acc1_q, acc2_q;
   logic             zero_q, neg_q, carry_q, ovf_q, rdy_q;

   logic [WIDTH-1:0] hi_d, lo_d;
   logic [WIDTH:0]   mul_sum, rem_sh;
   logic             rem_ge;

   logic [WIDTH-1:0] add_b, sub_b;
   logic [WIDTH:0]   add_w, sub_w, shr_w, shl_w;
   logic [SH_W-1:0]  sh;
   logic [WIDTH-1:0] r_res, r_acc1, r_acc2;
   logic             r_z, r_n, r_c, r_v, r_upd;
   logic             is_iter, last;

   logic unused_imm;
   assign unused_imm = bus.opcode[0];

   // One iteration step: hi:lo is the product register for MUL, remainder:quotient for DIV/MOD
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_ge  = rem_sh >= {1'b0, b_q};
      if (op_q == OP_MUL) begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (rem_ge) begin
         hi_d = WIDTH'(rem_sh - {1'b0, b_q});
         lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         hi_d = rem_sh[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      sh     = b_q[SH_W-1:0];
      add_b  = (op_q == OP_INC) ? WIDTH'(1) : b_q;
      sub_b  = (op_q == OP_DEC) ? WIDTH'(1) : b_q;
      add_w  = {1'b0, a_q} + {1'b0, add_b};
      sub_w  = {1'b0, a_q} - {1'b0, sub_b};
      // Shifts carry an extra bit so the last bit shifted out falls into it
      shr_w  = {a_q, 1'b0} >> sh;
      shl_w  = {1'b0, a_q} << sh;

      r_upd  = 1'b1;
      r_res  = '0;
      r_acc1 = '0;
      r_acc2 = '0;
      r_c    = 1'b0;
      r_v    = 1'b0;

      case (op_q)
         OP_ADD, OP_INC: begin
            r_res = add_w[WIDTH-1:0];
            r_c   = add_w[WIDTH];
            r_v   = add_ovf(a_q, add_b, r_res);
         end
         OP_SUB, OP_DEC, OP_CMP: begin
            r_res = sub_w[WIDTH-1:0];
            r_c   = sub_w[WIDTH];
            r_v   = sub_ovf(a_q, sub_b, r_res);
         end
         OP_LSR: begin
            r_res = shr_w[WIDTH:1];
            r_c   = shr_w[0];
         end
         OP_LSL: begin
            r_res = shl_w[WIDTH-1:0];
            r_c   = shl_w[WIDTH];
         end
         OP_RSR: r_res = WIDTH'({a_q, a_q} >> sh);
         OP_RSL: r_res = WIDTH'(({a_q, a_q} << sh) >> WIDTH);
         OP_MOV: r_res = b_q;
         OP_AND, OP_TST: r_res = a_q & b_q;
         OP_OR:  r_res = a_q | b_q;
         OP_XOR: r_res = a_q ^ b_q;
         OP_NOT: r_res = ~a_q;
         OP_MUL: begin
            r_res  = lo_d;
            r_acc2 = hi_d;
            r_c    = |hi_d;
         end
         OP_DIV: begin
            r_res  = (b_q == '0) ? '1  : lo_d;
            r_acc2 = (b_q == '0) ? a_q : hi_d;
            r_v    = (b_q == '0);
         end
         OP_MOD: begin
            r_res  = (b_q == '0) ? a_q : hi_d;
            r_acc2 = (b_q == '0) ? '1  : lo_d;
            r_v    = (b_q == '0);
         end
         default: r_upd = 1'b0;
      endcase

      r_acc1 = (op_q == OP_CMP || op_q == OP_TST) ? a_q : r_res;
      r_z    = (r_res == '0);
      r_n    = r_res[WIDTH-1];
      if (op_q == OP_MUL) begin
         r_z = ({hi_d, lo_d} == '0);
         r_n = 1'b0;
      end else if (op_q == OP_DIV || op_q == OP_MOD) begin
         r_n = 1'b0;
      end

      is_iter = (op_q == OP_MUL) || ((op_q == OP_DIV || op_q == OP_MOD) && (b_q != '0));
      last    = !is_iter || (cnt_q == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.bgn) begin
                  op_q    <= bus.opcode[5:1];
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  hi_q    <= '0;
                  lo_q    <= bus.A;
                  cnt_q   <= '0;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (last) begin
                  // HLT/NOP/undefined finish the handshake but leave results untouched
                  if (r_upd) begin
                     acc1_q  <= r_acc1;
                     acc2_q  <= r_acc2;
                     zero_q  <= r_z;
                     neg_q   <= r_n;
                     carry_q <= r_c;
                     ovf_q   <= r_v;
                  end
                  rdy_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (!bus.bgn) begin
                  rdy_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.acc1     = acc1_q;
   assign bus.acc2     = acc2_q;
   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = ovf_q;
   assign bus.rdy      = rdy_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle arithmetic/logic unit that is the responder side of the control unit's `bgn`/`rdy` execute handshake. It latches an opcode and two operands on `bgn`, produces a 16-bit primary result (`acc1`), a secondary result (`acc2`) and four flags, then holds `rdy` until the control unit drops `bgn`. Single-cycle ops complete in one EXEC cycle; MUL/DIV/MOD use iterative shift-add and restoring division.

## Interface
- `WIDTH`, 16, datapath width; iteration count for MUL/DIV/MOD; shift amount is `B[$clog2(WIDTH)-1:0]`.
- `clk` input 1 — clock; all state updates on the rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `bgn` input 1 — start request from the control unit; level-sensitive.
- `opcode` input 6 — operation field is `opcode[5:1]`; `opcode[0]` (immediate select) is ignored here.
- `A` input WIDTH — operand A.
- `B` input WIDTH — operand B.
- `acc1` output WIDTH — primary result (registered).
- `acc2` output WIDTH — secondary result: MUL high half, DIV remainder, MOD quotient; 0 otherwise.
- `zero`, `negative`, `carry`, `overflow` output 1 each — registered flags.
- `rdy` output 1 — result valid; held high until `bgn` is low.

## Operation
- Op codes (`opcode[5:1]`): HLT 00000, ADD 00001, SUB 00010, LSR 00011, LSL 00100, RSR 00101, RSL 00110, MOV 00111, MUL 01000, DIV 01001, MOD 01010, AND 01011, OR 01100, XOR 01101, NOT 01110, CMP 01111, TST 10000, INC 10001, DEC 10010, NOP 11111.
- States:
  - IDLE: on `bgn`=1, latch `opcode`, `A`, `B`; clear the counter; go to EXEC.
  - EXEC: single-cycle ops write results, set `rdy`, go to DONE. MUL/DIV/MOD perform one step per cycle and, after step WIDTH, write results, set `rdy`, go to DONE.
  - DONE: `rdy`=1; on `bgn`=0 clear `rdy` and go to IDLE.
- ADD/INC: `{carry,acc1}=A+B` (INC: `A+1`). `overflow` = signed overflow.
- SUB/DEC/CMP: `A-B` (DEC: `A-1`). `carry` = borrow (unsigned A<B). `overflow` = signed overflow. CMP sets flags only; `acc1`=A.
- LSR/LSL: logical shift by `B[3:0]`. `carry` = last bit shifted out (0 if the amount is 0). RSR/RSL: rotate; `carry`=0. `overflow`=0.
- AND/OR/XOR: bitwise. NOT: `~A`. TST: flags from `A&B`, `acc1`=A. MOV: `acc1`=B. All of these clear `carry` and `overflow`.
- MUL: unsigned, `{acc2,acc1}=A*B`. `carry` = (`acc2`!=0). `zero` = (32-bit product == 0). `negative`=0, `overflow`=0.
- DIV: `acc1`=A/B, `acc2`=A%B. MOD: `acc1`=A%B, `acc2`=A/B. Both unsigned, with `carry`, `overflow`, `negative` = 0.
- Divide by zero (DIV/MOD with B=0): single-cycle; quotient=16'hFFFF, remainder=A, `overflow`=1.
- Flags: unless stated above, `zero` = (result==0) and `negative` = result[15], where result is the computed value (for CMP/TST, the internal value).
- HLT/NOP/undefined: outputs and flags keep their previous values; `rdy` still asserted after one EXEC cycle.
- Outputs change only on the EXEC→DONE edge and hold until the next completion.

## Timing
- Reset: state IDLE, counter 0, `acc1`=`acc2`=0, all flags 0, `rdy`=0. `rst` mid-operation aborts the op with no result.
- Let `bgn` be sampled high in IDLE at edge N.
  - Single-cycle ops: `rdy`=1 after edge N+1.
  - MUL/DIV/MOD: `rdy`=1 after edge N+WIDTH (N+16).
- `A`, `B`, `opcode` changes after edge N are ignored until the next IDLE.
- `bgn` dropping during EXEC does not abort; the op completes, and DONE then exits on the next edge.
- `rdy` falls on the first edge at which DONE samples `bgn`=0. A new op requires `bgn` low for ≥1 edge, so back-to-back ops have a minimum one-cycle IDLE gap.
- `bgn` held high in DONE keeps `rdy` high indefinitely; there is no re-trigger.

## Test plan
- Reset then idle: `rst` high for 2 cycles -> all outputs 0, `rdy` stays 0 with `bgn`=0.
- ADD A=16'h7FFF, B=1 -> `rdy` after edge N+1; `acc1`=16'h8000, `negative`=1, `overflow`=1, `carry`=0. Then drop `bgn` -> `rdy`=0 next edge.
- SUB A=3, B=5 -> `acc1`=16'hFFFE, `carry`=1, `negative`=1. CMP A=5, B=5 -> `zero`=1, `acc1`=5.
- MUL A=16'h1234, B=16'h0100 -> `rdy` after edge N+16; `acc2`=16'h0012, `acc1`=16'h3400, `carry`=1. Operands changed mid-op -> same result.
- DIV A=100, B=7 -> `acc1`=14, `acc2`=2 at N+16. DIV A=9, B=0 -> `acc1`=16'hFFFF, `acc2`=9, `overflow`=1, `rdy` at N+1.
- Abort and hold: `rst` asserted during MUL step 8 -> IDLE, outputs 0, no `rdy`. LSL A=16'h8001, B=1 -> `acc1`=16'h0002, `carry`=1; with `bgn` held high, `rdy` stays 1 and the result is stable.
